switch_debounce: RTL and testbench

//   Conditions the raw board slide switches before the NIOS2 switches PIO samples them.
//   - Synchronises each asynchronous switch to clk.
//   - Debounces each bit independently.
//   - Drives the stable vector straight into the PIO in_port.
//   - Sits between the top-level SW pins and the Qsys nios2 system.

---
 rtl/switch_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 77 +++++++
 rtl/switch_debounce.sv | 56 +++++
 tb/tb_switch_debounce.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants and helpers for the slide-switch conditioning block.
// Defaults match the 18-switch board at 50 MHz with a 10 ms debounce window.
package switch_pkg;

    localparam int SW_WIDTH             = 18;
    localparam int SW_SYNC_STAGES_DEF   = 2;
    localparam int SW_STABLE_CYCLES_DEF = 500000;

    // A bit is STABLE while its synchronised input matches the accepted
    // level and PENDING while a new level is being timed.
    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    // Counter wide enough to hold 0 .. stable.
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, hold-time counter and accepted level.
// The level only moves after the new value has held for STABLE_CYCLES clocks.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES   = SW_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_bit: SYNC_STAGES must be at least 2");
    end

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_bit: STABLE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    db_state_e              state;

    assign s     = sync_q[SYNC_STAGES-1];
    assign level = level_q;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Time how long the synchronised input has disagreed with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        state   = (s == level_q) ? DB_STABLE : DB_PENDING;
        unique case (state)
            DB_STABLE: begin
                cnt_d = '0;
            end
            DB_PENDING: begin
                if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Hold-time counter and accepted level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the board slide switches for the switches PIO.
// Optional change pulses are built when SWITCH_DEBOUNCE_CHANGE_PULSE_EN is defined.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = SW_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_change_any
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .level (sw_out[i])
        );
    end

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN

    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] chg_q;

    // Registered old^new of the accepted level: one-cycle pulse per toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            chg_q  <= '0;
        end else begin
            last_q <= sw_out;
            chg_q  <= sw_out ^ last_q;
        end
    end

    assign sw_changed    = chg_q;
    assign sw_change_any = |chg_q;

`else

    assign sw_changed    = '0;
    assign sw_change_any = 1'b0;

`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (WIDTH=18, SYNC_STAGES=2, STABLE_CYCLES=8).
// Expected change pulses follow SWITCH_DEBOUNCE_CHANGE_PULSE_EN as built.
module tb_switch_debounce;
    import switch_pkg::*;

    localparam int W   = 18;
    localparam int SS  = 2;
    localparam int SC  = 8;
    localparam int LAT = SS + SC;

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    localparam logic [W-1:0] ALL = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_changed;
    logic         sw_change_any;

    int errors = 0;
    int checks = 0;

    switch_debounce #(
        .WIDTH         (W),
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_raw        (sw_raw),
        .sw_out        (sw_out),
        .sw_changed    (sw_changed),
        .sw_change_any (sw_change_any)
    );

    always #5 clk = ~clk;

    // Reference model: s is the raw vector seen SS edges ago; a bit is
    // accepted once its last SC samples of s all disagree with the level.
    logic [W-1:0] raw_q[$];
    logic [W-1:0] s_q[$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_chg;

    task automatic model_reset();
        raw_q  = {};
        s_q    = {};
        m_out  = '0;
        m_prev = '0;
        m_chg  = '0;
        repeat (SS) raw_q.push_back('0);
        repeat (SC) s_q.push_back('0);
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] s;
        logic [W-1:0] old;
        bit           all_diff;
        s = raw_q.pop_front();
        raw_q.push_back(raw);
        void'(s_q.pop_front());
        s_q.push_back(s);
        old    = m_out;
        m_chg  = PULSE ? (m_out ^ m_prev) : '0;
        m_prev = old;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (s_q[j]) begin
                if (s_q[j][i] == old[i]) all_diff = 1'b0;
            end
            if (all_diff) m_out[i] = s[i];
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(sw_raw);
        #1;
        check("model_out", sw_out, m_out);
        check("model_chg", sw_changed, m_chg);
        check("model_any", {{(W-1){1'b0}}, sw_change_any},
              {{(W-1){1'b0}}, |m_chg});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_out", sw_out, '0);
        check("rst_chg", sw_changed, '0);
        check("rst_any", {{(W-1){1'b0}}, sw_change_any}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] m;

        vecs[0] = '{18'h00001, 9,  18'h00000};
        vecs[1] = '{18'h00001, 1,  18'h00001};
        vecs[2] = '{18'h00021, 5,  18'h00001};
        vecs[3] = '{18'h00001, 2,  18'h00001};
        vecs[4] = '{18'h00021, 9,  18'h00001};
        vecs[5] = '{18'h00021, 1,  18'h00021};
        vecs[6] = '{18'h20021, 7,  18'h00021};
        vecs[7] = '{18'h00021, 12, 18'h00021};
        vecs[8] = '{18'h00000, 10, 18'h00000};

        // Switches held high through reset reach the output after LAT edges.
        sw_raw = ALL;
        apply_reset();
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            check("t1_out", sw_out, (k >= LAT) ? ALL : '0);
            check("t1_chg", sw_changed, (PULSE && k == LAT + 1) ? ALL : '0);
        end

        sw_raw = '0;
        repeat (LAT + 2) tick();
        check("fall_all", sw_out, '0);

        // Step, bounce, glitch and simultaneous release.
        foreach (vecs[v]) begin
            sw_raw = vecs[v].raw;
            repeat (vecs[v].hold) tick();
            check($sformatf("vec%0d", v), sw_out, vecs[v].exp);
        end

        // Random toggling, each bit flipping about once every 12 cycles.
        for (int n = 0; n < 400; n++) begin
            m = '0;
            for (int i = 0; i < W; i++) m[i] = ($urandom_range(0, 11) == 0);
            sw_raw = sw_raw ^ m;
            tick();
        end

        sw_raw = '0;
        repeat (LAT + 2) tick();

        // Reset in the middle of a pending rise discards the count.
        sw_raw = 18'h10000;
        repeat (LAT + 2) tick();
        check("t5_pre", sw_out, 18'h10000);
        sw_raw = 18'h10008;
        repeat (SS + 5) tick();
        check("t5_pend", sw_out, 18'h10000);
        apply_reset();
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("t5_out", sw_out, (k >= LAT) ? 18'h10008 : '0);
        end
        tick();
        check("t5_chg", sw_changed, PULSE ? 18'h10008 : '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
